muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the execute-stage ALU. The pipeline issues an op with a valid/ready handshake and stalls decode/fetch while the unit is busy.
- The result and destination tag return through a second valid/ready handshake, which feeds the writeback mux.
- Generalises the single-cycle ALU in width (XLEN), in mode (new ops), and in throughput (UNROLL bits per iteration).

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute stage.
// Shift-add multiply, restoring divide, UNROLL bits per cycle.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out,
  output logic            busy
);

  localparam int K  = XLEN / UNROLL;
  localparam int CW = $clog2(K + 1);
  localparam logic [XLEN-1:0] ZERO = '0;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [TAGW-1:0]   tag_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   res_q;
  logic [TAGW-1:0]   tag_out_q;

  logic            accept;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign tag_out   = tag_out_q;

  assign accept = in_valid & in_ready & ~kill;
  assign is_div = funct3[2];

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b001): begin sgn_a = 1'b1; sgn_b = 1'b1; end
      (funct3 == 3'b010): begin sgn_a = 1'b1; end
      (funct3 == 3'b100),
      (funct3 == 3'b110): begin sgn_a = 1'b1; sgn_b = 1'b1; end
      default: ;
    endcase
  end

  assign a_neg  = sgn_a & a[XLEN-1];
  assign b_neg  = sgn_b & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == ZERO);
  assign ovf    = is_div & ~funct3[0] & (a == MIN) & (b == ONES);
  assign fast   = is_div & (b_zero | ovf);

  // Divide-by-zero and signed overflow bypass the iteration entirely
  always_comb begin
    if (b_zero) fast_res = funct3[1] ? a : ONES;
    else        fast_res = funct3[1] ? ZERO : a;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // acc = {partial high / remainder, multiplier / quotient}
  logic [XLEN:0] sum;
  logic [XLEN:0] prem;
  logic [XLEN:0] diff;

  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    prem  = '0;
    diff  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        sum   = {1'b0, acc_d[2*XLEN-1:XLEN]}
              + {1'b0, (acc_d[0] ? mag_a_q : ZERO)};
        acc_d = {sum, acc_d[XLEN-1:1]};
      end else begin
        prem = acc_d[2*XLEN-1:XLEN-1];
        diff = prem - {1'b0, mag_b_q};
        if (!diff[XLEN])
          acc_d = {diff[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
        else
          acc_d = {prem[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN]
                     : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00)
      fix_res = prod[XLEN-1:0];
    else
      fix_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      tag_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      tag_out_q <= '0;
    end else if (accept) begin
      op_q      <= funct3;
      tag_q     <= tag_in;
      mag_a_q   <= a_mag;
      mag_b_q   <= b_mag;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      cnt_q     <= CW'(K);
      acc_q     <= is_div ? {ZERO, a_mag} : {ZERO, b_mag};
      if (fast) begin
        res_q     <= fast_res;
        tag_out_q <= tag_in;
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
    end else if (state_q == FIX && !kill) begin
      res_q     <= fix_res;
      tag_out_q <= tag_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, corner sequences and
// random ops on a 32-bit and a 16-bit/UNROLL=4 instance.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 0, ir32, k32 = 0, ov32, or32 = 0, bz32;
  logic [2:0]  f32 = 0;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic [4:0]  t32 = 0, to32;

  logic        iv16 = 0, ir16, k16 = 0, ov16, or16 = 0, bz16;
  logic [2:0]  f16 = 0;
  logic [15:0] a16 = 0, b16 = 0, r16;
  logic [4:0]  t16 = 0, to16;

  muldiv_unit u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .funct3(f32), .a(a32), .b(b32), .tag_in(t32), .kill(k32),
    .out_valid(ov32), .out_ready(or32), .result(r32), .tag_out(to32),
    .busy(bz32)
  );

  muldiv_unit #(.XLEN(16), .UNROLL(4), .TAGW(5)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .funct3(f16), .a(a16), .b(b16), .tag_in(t16), .kill(k16),
    .out_valid(ov16), .out_ready(or16), .result(r16), .tag_out(to16),
    .busy(bz16)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RV32M rules on w-bit values using wide plain arithmetic
  function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [127:0] one, mask, ua, ub, sa, sb, r;
    logic ovf;
    one  = 1;
    mask = (one <<< w) - one;
    ua   = {96'b0, a} & mask;
    ub   = {96'b0, b} & mask;
    sa   = ua;
    sb   = ub;
    if (ua[w-1]) sa = ua - (one <<< w);
    if (ub[w-1]) sb = ub - (one <<< w);
    ovf = (ua == (one <<< (w - 1))) && (ub == mask);
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >>> w;
      3'd4: r = (ub == 0) ? -one : (ovf ? ua : sa / sb);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : (ovf ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m, mn;
    m  = (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
    mn = (w == 16) ? 32'h00008000 : 32'h80000000;
    if (f[2] && ((b & m) == 0 || (!f[0] && (a & m) == mn && (b & m) == m)))
      return 1;
    return (w == 16) ? 6 : 34;
  endfunction

  // Issue one op, wait for the result, then pop it with out_ready
  task automatic do_op(input int w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] res,
                       output logic [4:0] tg, output int lat);
    @(negedge clk);
    if (w == 16) begin
      iv16 = 1; f16 = f; a16 = a[15:0]; b16 = b[15:0]; t16 = tag;
    end else begin
      iv32 = 1; f32 = f; a32 = a; b32 = b; t32 = tag;
    end
    @(posedge clk);
    #1;
    iv16 = 0;
    iv32 = 0;
    lat = 1;
    @(negedge clk);
    while (!((w == 16) ? ov16 : ov32) && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    res = (w == 16) ? {16'b0, r16} : r32;
    tg  = (w == 16) ? to16 : to32;
    or16 = 1;
    or32 = 1;
    @(posedge clk);
    #1;
    or16 = 0;
    or32 = 0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    bit          seen;

    vecs[0]  = '{3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    vecs[12] = '{3'd4, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1};

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, ir32}, 32'd1);
    check("rst_out_valid", {31'b0, ov32}, 32'd0);
    check("rst_busy", {31'b0, bz32}, 32'd0);
    check("rst_result", r32, 32'd0);
    check("rst_tag", {27'b0, to32}, 32'd0);
    reset_n = 1;

    for (int i = 0; i < 14; i++) begin
      do_op(32, vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 3), res, tg, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), {27'b0, tg}, 32'(i + 3));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held, unit stays busy until popped
    @(negedge clk);
    iv32 = 1; f32 = 3'd0; a32 = 3; b32 = 5; t32 = 9;
    @(posedge clk);
    #1 iv32 = 0;
    lat = 0;
    while (!ov32 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_reached_done", {31'b0, ov32}, 32'd1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("bp_result", r32, 32'd15);
      check("bp_flags", {29'b0, ov32, ir32, bz32}, 32'b101);
    end
    or32 = 1;
    @(posedge clk);
    #1 or32 = 0;
    check("bp_release", {29'b0, ov32, ir32, bz32}, 32'b010);

    // Kill mid-CALC
    @(negedge clk);
    iv32 = 1; f32 = 3'd5; a32 = 1000; b32 = 7; t32 = 4;
    @(posedge clk);
    #1 iv32 = 0;
    repeat (5) @(negedge clk);
    k32 = 1;
    @(posedge clk);
    #1 k32 = 0;
    check("kill_idle", {29'b0, ov32, ir32, bz32}, 32'b010);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1;
    end
    check("kill_no_out", {31'b0, seen}, 32'd0);
    do_op(32, 3'd0, 32'd3, 32'd4, 5'd11, res, tg, lat);
    check("post_kill_mul", res, 32'd12);
    check("post_kill_lat", 32'(lat), 32'd34);

    // kill with in_valid in IDLE: op must not be taken
    @(negedge clk);
    iv32 = 1; k32 = 1; f32 = 3'd0; a32 = 1; b32 = 1;
    @(posedge clk);
    #1 begin iv32 = 0; k32 = 0; end
    check("kill_idle_accept", {30'b0, ir32, bz32}, 32'b10);
    repeat (3) @(negedge clk);
    check("kill_idle_no_out", {31'b0, ov32}, 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    iv32 = 1; f32 = 3'd0; a32 = 6; b32 = 7; t32 = 21;
    @(posedge clk);
    #1 iv32 = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("arst_flags", {29'b0, ov32, ir32, bz32}, 32'b010);
    check("arst_result", r32, 32'd0);
    check("arst_tag", {27'b0, to32}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1;
    end
    check("arst_no_out", {31'b0, seen}, 32'd0);

    // Random ops against the reference model on both instances
    for (int n = 0; n < 210; n++) begin
      int          w, m;
      logic [2:0]  f;
      logic [31:0] a, b, msk, mn;
      logic [4:0]  tag;
      w   = (n < 150) ? 16 : 32;
      msk = (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
      mn  = (w == 16) ? 32'h00008000 : 32'h80000000;
      f   = 3'($urandom_range(0, 7));
      a   = $urandom & msk;
      b   = $urandom & msk;
      tag = 5'($urandom);
      m   = $urandom_range(0, 9);
      if (m == 0) b = 0;
      if (m == 1) begin a = mn; b = msk; end
      if (m == 2) b = $urandom_range(1, 15);
      if (m == 3) a = mn;
      do_op(w, f, a, b, tag, res, tg, lat);
      check($sformatf("rnd%0d f=%0d a=%h b=%h result", w, f, a, b),
            res, ref_op(w, f, a, b));
      check($sformatf("rnd%0d tag", w), {27'b0, tg}, {27'b0, tag});
      check($sformatf("rnd%0d f=%0d latency", w, f), 32'(lat),
            32'(ref_lat(w, f, a, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
